// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port ram between instruction fetch (I, read-only)
// and load/store (D). A winning request is latched onto the Ram_* bus. The arbiter
// then waits for Ram_ack or a timeout, and returns data or an error to the winner.
// Optional build macro RAM_ARB_ROUND_ROBIN_EN: when both ports request together,
// the grant alternates between them. Without it, D always wins ties.

module ram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [DATA_W-1:0] I_rdata,
    output logic              I_ack,
    output logic              I_err,
    input  logic              D_req,
    input  logic              D_we,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_ack,
    output logic              D_err,
    output logic [ADDR_W-1:0] Ram_addr,
    output logic              Ram_cs,
    output logic              Ram_we,
    output logic [DATA_W-1:0] Ram_wdata,
    input  logic [DATA_W-1:0] Ram_rdata,
    input  logic              Ram_ack,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester raises x_req with its fields and holds them until x_ack.
    // x_ack is a single-cycle pulse, and x_err qualifies it. The requester drops x_req
    // in the next cycle unless it wants another access. On the ram side, Ram_cs stays
    // high with stable fields until the cycle in which Ram_ack=1 is seen.

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            busy_i;
    logic            busy_d;
    logic            expired;
    logic            done;
    logic            grant_d;
    logic            tie_to_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic            last_grant_d;   // 1 = D was the last port to complete
`endif

    assign dbg_state = state;

    // Decode the current transaction's completion and route the ram response to the
    // winner only.
    always_comb begin
        busy_i  = (state == BUSY_I);
        busy_d  = (state == BUSY_D);
        expired = (timer == T_LAST);
        done    = (busy_i || busy_d) && (Ram_ack || expired);
        I_ack   = busy_i && (Ram_ack || expired);
        D_ack   = busy_d && (Ram_ack || expired);
        I_err   = busy_i && !Ram_ack && expired;
        D_err   = busy_d && !Ram_ack && expired;
        I_rdata = (busy_i && Ram_ack) ? Ram_rdata : '0;
        D_rdata = (busy_d && Ram_ack) ? Ram_rdata : '0;
    end

    // Pick the winner in IDLE; a tie goes to D unless rotation is enabled.
    always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        tie_to_d = !last_grant_d;
`else
        tie_to_d = 1'b1;
`endif
        grant_d = D_req && (!I_req || tie_to_d);
    end

    // Arbitration FSM: latch the winner onto the ram bus, then wait for ack or timeout.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            timer     <= '0;
            Ram_cs    <= 1'b0;
            Ram_we    <= 1'b0;
            Ram_addr  <= '0;
            Ram_wdata <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (grant_d) begin
                        state     <= BUSY_D;
                        Ram_cs    <= 1'b1;
                        Ram_we    <= D_we;
                        Ram_addr  <= D_addr;
                        Ram_wdata <= D_wdata;
                    end else if (I_req) begin
                        state     <= BUSY_I;
                        Ram_cs    <= 1'b1;
                        Ram_we    <= 1'b0;
                        Ram_addr  <= I_addr;
                        Ram_wdata <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done) begin
                        state  <= IDLE;
                        Ram_cs <= 1'b0;
                        timer  <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        if (Ram_ack) begin
                            last_grant_d <= busy_d;
                        end
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    Ram_cs <= 1'b0;
                    timer  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random and directed traffic on both ports. A behavioural ram
// responds with random latency. Results are checked against a transaction-level
// memory image and against the arbitration rule.
module tb_ram_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              I_req = 1'b0;
    logic [ADDR_W-1:0] I_addr = '0;
    logic [DATA_W-1:0] I_rdata;
    logic              I_ack, I_err;
    logic              D_req = 1'b0, D_we = 1'b0;
    logic [ADDR_W-1:0] D_addr = '0;
    logic [DATA_W-1:0] D_wdata = '0;
    logic [DATA_W-1:0] D_rdata;
    logic              D_ack, D_err;
    logic [ADDR_W-1:0] Ram_addr;
    logic              Ram_cs, Ram_we;
    logic [DATA_W-1:0] Ram_wdata;
    logic [DATA_W-1:0] Ram_rdata = '0;
    logic              Ram_ack = 1'b0;
    logic [1:0]        dbg_state;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst),
        .I_req(I_req), .I_addr(I_addr), .I_rdata(I_rdata), .I_ack(I_ack), .I_err(I_err),
        .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_ack(D_ack), .D_err(D_err),
        .Ram_addr(Ram_addr), .Ram_cs(Ram_cs), .Ram_we(Ram_we), .Ram_wdata(Ram_wdata),
        .Ram_rdata(Ram_rdata), .Ram_ack(Ram_ack), .dbg_state(dbg_state)
    );

    // clock
    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference memory image at transaction level
    logic [DATA_W-1:0] ref_mem [int];
    function automatic logic [DATA_W-1:0] ref_get(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // behavioural ram: ack after 'lat' cycles of Cs; noise on ack/rdata otherwise
    logic [DATA_W-1:0] ram_mem [int];
    int cnt = 0, lat = 1, force_lat = 0;
    bit ram_dead = 1'b0;
    always begin
        @(posedge Clk); #1;
        if (Ram_cs) begin
            cnt++;
            if (!ram_dead && cnt == lat) begin
                Ram_ack   = 1'b1;
                Ram_rdata = ram_mem.exists(int'(Ram_addr)) ? ram_mem[int'(Ram_addr)] : '0;
                if (Ram_we) ram_mem[int'(Ram_addr)] = Ram_wdata;
            end else begin
                Ram_ack   = 1'b0;
                Ram_rdata = $urandom;
            end
        end else begin
            cnt       = 0;
            lat       = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
            Ram_ack   = 1'($urandom_range(0, 1));
            Ram_rdata = $urandom;
        end
    end

    // scoreboard / monitor
    typedef struct {
        bit                is_d;
        logic [DATA_W-1:0] rdata;
        bit                err;
        int                len;
    } ack_t;
    ack_t ack_log[$];
    int acc_cnt = 0, i_ack_cnt = 0, d_ack_cnt = 0, cs_len = 0;
    logic prev_cs = 1'b0;
    logic [ADDR_W-1:0] acc_addr = '0;
    logic acc_we = 1'b0;
    logic [DATA_W-1:0] acc_wdata = '0;
    bit model_last_d = 1'b0;

    always @(negedge Clk) begin
        if (!Rst) model_last_d = 1'b0;
        if (Ram_cs) begin
            cs_len = prev_cs ? cs_len + 1 : 1;
            if (!prev_cs) begin
                acc_cnt++;
                acc_addr  = Ram_addr;
                acc_we    = Ram_we;
                acc_wdata = Ram_wdata;
            end
        end
        prev_cs = Ram_cs;
        if (I_ack) begin
            i_ack_cnt++;
            check("i_ack_only_with_cs", Ram_cs, 1);
            check("d_ack_idle_during_i", D_ack, 0);
            check("d_rdata_zero_during_i", D_rdata, 0);
            ack_log.push_back('{is_d: 1'b0, rdata: I_rdata, err: I_err, len: cs_len});
            if (!I_err) model_last_d = 1'b0;
        end
        if (D_ack) begin
            d_ack_cnt++;
            check("d_ack_only_with_cs", Ram_cs, 1);
            check("i_ack_idle_during_d", I_ack, 0);
            check("i_rdata_zero_during_d", I_rdata, 0);
            ack_log.push_back('{is_d: 1'b1, rdata: D_rdata, err: D_err, len: cs_len});
            if (!D_err) model_last_d = 1'b1;
        end
    end

    // driver tasks
    task automatic start_d(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        D_req = 1'b1; D_we = we; D_addr = a; D_wdata = wd;
    endtask

    task automatic start_i(input logic [ADDR_W-1:0] a);
        I_req = 1'b1; I_addr = a;
    endtask

    task automatic wait_acks(input int n, input int bound);
        int k = 0;
        while (ack_log.size() < n && k < bound) begin
            @(negedge Clk); #1; k++;
        end
        check("ack_wait_bound", ack_log.size() >= n, 1);
    endtask

    task automatic wait_cs(input int bound);
        int k = 0;
        while (!Ram_cs && k < bound) begin
            @(negedge Clk); k++;
        end
        check("cs_wait_bound", Ram_cs, 1);
    endtask

    // one isolated access, checked against the reference image
    task automatic single(input bit is_d, input bit we, input int a, input logic [DATA_W-1:0] wd);
        int acc0, n0;
        ack_t r;
        acc0 = acc_cnt;
        n0 = ack_log.size();
        @(posedge Clk); #1;
        if (is_d) start_d(we, ADDR_W'(a), wd);
        else start_i(ADDR_W'(a));
        wait_acks(n0 + 1, 64);
        @(posedge Clk); #1;
        D_req = 1'b0; I_req = 1'b0;
        check("single_acc_count", acc_cnt - acc0, 1);
        check("single_acc_addr", acc_addr, ADDR_W'(a));
        check("single_acc_we", acc_we, is_d & we);
        if (is_d && we) check("single_acc_wdata", acc_wdata, wd);
        if (ack_log.size() > n0) begin
            r = ack_log[n0];
            check("single_port", r.is_d, is_d);
            check("single_err", r.err, 0);
            if (!we) check("single_rdata", r.rdata, ref_get(a));
        end
        if (is_d && we) ref_mem[a] = wd;
    endtask

    // both ports held; each drops its request the cycle after its own ack
    task automatic serve_both(input int n0, input int bound);
        int k = 0;
        while (ack_log.size() < n0 + 2 && k < bound) begin
            @(posedge Clk); #1; k++;
            for (int j = n0; j < ack_log.size(); j++) begin
                if (ack_log[j].is_d) D_req = 1'b0;
                else I_req = 1'b0;
            end
        end
        check("serve_both_bound", ack_log.size() >= n0 + 2, 1);
        @(posedge Clk); #1;
        D_req = 1'b0; I_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clk); Rst = 1'b0;
        D_req = 1'b0; I_req = 1'b0;
        @(negedge Clk); Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    initial begin
        int n0, acc0, dcnt0, ad, ai;
        bit e_d, last;
        bit rd_is_d, rd_we;

        // reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_cs", Ram_cs, 0);
        check("rst_we", Ram_we, 0);
        check("rst_addr", Ram_addr, 0);
        check("rst_wdata", Ram_wdata, 0);
        check("rst_acks", {I_ack, D_ack, I_err, D_err}, 0);
        check("rst_rdata", {I_rdata, D_rdata}, 0);
        check("rst_state", dbg_state, 0);
        @(negedge Clk); Rst = 1'b1;
        repeat (2) @(posedge Clk);

        // D write then I fetch of the same word
        single(1'b1, 1'b1, 4, 32'hbbbbbbbb);
        single(1'b0, 1'b0, 4, '0);
        check("wr_then_fetch_data", ack_log[ack_log.size()-1].rdata, 32'hbbbbbbbb);

        // random isolated accesses
        repeat (40) begin
            rd_is_d = 1'($urandom_range(0, 1));
            rd_we   = rd_is_d & 1'($urandom_range(0, 1));
            single(rd_is_d, rd_we, 4 * $urandom_range(0, 15), $urandom);
        end

        // simultaneous requests: arbitration order, separate accesses with Cs gap
        repeat (6) begin
            n0 = ack_log.size();
            acc0 = acc_cnt;
            ad = (n0 % 2 == 0) ? 8 : 4 * $urandom_range(0, 15);
            ai = 4 * $urandom_range(0, 15);
            @(posedge Clk); #1;
            e_d = RR ? !model_last_d : 1'b1;
            start_d(1'b0, ADDR_W'(ad), '0);
            start_i(ADDR_W'(ai));
            serve_both(n0, 64);
            check("tie_acc_count", acc_cnt - acc0, 2);
            if (ack_log.size() >= n0 + 2) begin
                check("tie_first", ack_log[n0].is_d, e_d);
                check("tie_second", ack_log[n0+1].is_d, !e_d);
                check("tie_first_rdata", ack_log[n0].rdata, ref_get(e_d ? ad : ai));
                check("tie_second_rdata", ack_log[n0+1].rdata, ref_get(e_d ? ai : ad));
            end
        end

        // both held for four transactions, starting from reset
        pulse_reset();
        n0 = ack_log.size();
        ad = 4 * $urandom_range(0, 7);
        ai = 32 + 4 * $urandom_range(0, 7);
        @(posedge Clk); #1;
        start_d(1'b0, ADDR_W'(ad), '0);
        start_i(ADDR_W'(ai));
        wait_acks(n0 + 4, 128);
        @(posedge Clk); #1;
        D_req = 1'b0; I_req = 1'b0;
        last = 1'b0;
        for (int j = 0; j < 4; j++) begin
            e_d = RR ? !last : 1'b1;
            last = e_d;
            if (ack_log.size() > n0 + j) begin
                check("held_grant", ack_log[n0+j].is_d, e_d);
                check("held_rdata", ack_log[n0+j].rdata, ref_get(e_d ? ad : ai));
            end
        end
        repeat (3) @(posedge Clk);

        // timeouts on both ports
        ram_dead = 1'b1;
        @(posedge Clk); #1;
        for (int p = 0; p < 2; p++) begin
            n0 = ack_log.size();
            @(posedge Clk); #1;
            if (p == 0) start_d(1'b0, 16'h000c, '0);
            else start_i(16'h0010);
            wait_acks(n0 + 1, 64);
            @(posedge Clk); #1;
            D_req = 1'b0; I_req = 1'b0;
            if (ack_log.size() > n0) begin
                check("to_port", ack_log[n0].is_d, p == 0);
                check("to_err", ack_log[n0].err, 1);
                check("to_rdata", ack_log[n0].rdata, 0);
                check("to_len", ack_log[n0].len, TIMEOUT);
            end
        end
        ram_dead = 1'b0;

        // ram ack in the final allowed cycle wins over the timeout
        force_lat = TIMEOUT;
        @(posedge Clk); #1;
        n0 = ack_log.size();
        single(1'b1, 1'b0, 8, '0);
        if (ack_log.size() > n0) check("last_cycle_len", ack_log[n0].len, TIMEOUT);
        force_lat = 0;

        // D drops req while busy: exactly one ack, no extra access
        force_lat = 4;
        @(posedge Clk); #1;
        n0 = ack_log.size();
        acc0 = acc_cnt;
        dcnt0 = d_ack_cnt;
        @(posedge Clk); #1;
        start_d(1'b0, 16'h0004, '0);
        wait_cs(20);
        @(posedge Clk); #1;
        D_req = 1'b0;
        wait_acks(n0 + 1, 32);
        repeat (8) @(posedge Clk);
        #1;
        check("drop_ack_count", d_ack_cnt - dcnt0, 1);
        check("drop_acc_count", acc_cnt - acc0, 1);
        if (ack_log.size() > n0) check("drop_rdata", ack_log[n0].rdata, ref_get(4));
        force_lat = 0;

        // reset in the middle of a D transaction
        ram_dead = 1'b1;
        @(posedge Clk); #1;
        dcnt0 = d_ack_cnt;
        start_d(1'b0, 16'h0010, '0);
        wait_cs(20);
        @(posedge Clk); #3;
        Rst = 1'b0;
        D_req = 1'b0;
        #1;
        check("midrst_cs_drop", Ram_cs, 0);
        check("midrst_no_ack", {D_ack, D_err}, 0);
        @(negedge Clk); Rst = 1'b1;
        ram_dead = 1'b0;
        repeat (TIMEOUT + 4) @(posedge Clk);
        #1;
        check("midrst_ack_count", d_ack_cnt - dcnt0, 0);
        check("midrst_idle", dbg_state, 0);
        check("midrst_cs_low", Ram_cs, 0);

        // one more access after the abort
        single(1'b1, 1'b1, 20, $urandom);
        single(1'b0, 1'b0, 20, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
